tiled_sa_controller: RTL

Sequencer for the systolic-array matrix engine. It computes C(k×n) = A(k×m)·B(m×n) on a fixed SA_ROWS×SA_COLS array by tiling C into ceil(k/SA_ROWS)×ceil(n/SA_COLS) output tiles. For each tile it generates skewed ifmaps/filters SRAM read addresses and feed enables, pulses an accumulator clear, and drains result rows to the ofmap writer over a valid/ready handshake. It replaces the single-tile controller: arbitrary k/n, partial-tile handling, backpressure, busy/done/error status.

---
 rtl/tiled_sa_pkg.sv | 32 +++
 rtl/sa_tile_counter.sv | 43 ++++
 rtl/tiled_sa_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tiled_sa_pkg.sv
// Shared definitions for the tiled systolic-array controller: FSM state
// encoding and small elaboration/arithmetic helpers used by the address units.
package tiled_sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Ceiling log2, used to size the drain-row index and shift amounts.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    // ceil(value / 2**shift) without a divider; callers truncate the result.
    function automatic logic [31:0] ceil_div_pow2(input logic [31:0] value, input int shift);
        logic [32:0] sum;
        logic [32:0] quot;
        sum  = {1'b0, value} + ((33'd1 << shift) - 33'd1);
        quot = sum >> shift;
        return quot[31:0];
    endfunction

endpackage

// File: rtl/sa_tile_counter.sv
// Nested output-tile counter: tc runs inner, tr advances on each tc wrap.
// Flags the final tile so the sequencer knows when the job is complete.
module sa_tile_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_adv,
    input  logic [WIDTH-1:0] i_num_rows,
    input  logic [WIDTH-1:0] i_num_cols,
    output logic [WIDTH-1:0] o_tr,
    output logic [WIDTH-1:0] o_tc,
    output logic             o_last_tile
);

    logic [WIDTH-1:0] r_tr;
    logic [WIDTH-1:0] r_tc;
    logic             w_last_col;
    logic             w_last_row;

    assign w_last_col  = (r_tc == i_num_cols - WIDTH'(1));
    assign w_last_row  = (r_tr == i_num_rows - WIDTH'(1));
    assign o_last_tile = w_last_col && w_last_row;
    assign o_tr        = r_tr;
    assign o_tc        = r_tc;

    // Advance column index, wrapping into the next tile row
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_tr <= '0;
            r_tc <= '0;
        end else if (i_adv) begin
            if (w_last_col) begin
                r_tc <= '0;
                r_tr <= r_tr + WIDTH'(1);
            end else begin
                r_tc <= r_tc + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/tiled_sa_controller.sv
// Tiled systolic-array sequencer: walks C = A*B tile by tile, issuing skewed
// SRAM read addresses and feed enables, clearing the accumulators per tile,
// and draining valid result rows to the ofmap writer under backpressure.
module tiled_sa_controller
    import tiled_sa_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int SRAM_ADDR_WIDTH = 10,
    parameter int SA_ROWS         = 4,
    parameter int SA_COLS         = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WIDTH-1:0]            k,
    input  logic [WIDTH-1:0]            m,
    input  logic [WIDTH-1:0]            n,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [SRAM_ADDR_WIDTH-1:0]  ifmaps_addr,
    output logic [SRAM_ADDR_WIDTH-1:0]  filters_addr,
    output logic                        enable_ifmaps_to_sa,
    output logic                        enable_filters_to_sa,
    output logic                        clear_acc,
    output logic                        ofmap_valid,
    output logic [SRAM_ADDR_WIDTH-1:0]  ofmap_addr,
    output logic [clog2(SA_ROWS)-1:0]   drain_row
);

    localparam int LOG_R = clog2(SA_ROWS);
    localparam int LOG_C = clog2(SA_COLS);
    localparam int XW    = WIDTH + 1;
    localparam int PW    = 2 * WIDTH + 2;
    localparam int AW    = SRAM_ADDR_WIDTH;

    state_t           r_state;
    logic [WIDTH-1:0] r_k, r_m, r_n;
    logic [XW-1:0]    r_t;
    logic [LOG_R-1:0] r_row;
    logic             r_busy, r_done, r_error, r_clear, r_valid;
    logic             r_en_i, r_en_f;
    logic [AW-1:0]    r_ifm_addr, r_fil_addr, r_ofm_addr;

    logic [WIDTH-1:0] w_nr, w_nt, w_tr, w_tc;
    logic             w_last_tile, w_last_row, w_zero, w_clr, w_adv;
    logic [XW-1:0]    w_li, w_lf, w_f_last, w_t_feed;
    logic [LOG_R-1:0] w_row_next;
    logic [PW-1:0]    w_grow_cur, w_grow_next;
    logic [AW-1:0]    w_ifm_next, w_fil_next, w_ofm_next;

    // Tile grid size and per-tile feed lengths, all from the captured dimensions
    assign w_nr     = WIDTH'(ceil_div_pow2(32'(r_k), LOG_R));
    assign w_nt     = WIDTH'(ceil_div_pow2(32'(r_n), LOG_C));
    assign w_li     = XW'(r_m) + XW'(SA_ROWS - 1);
    assign w_lf     = XW'(r_m) + XW'(SA_COLS - 1);
    assign w_f_last = XW'(r_m) + XW'(SA_ROWS + SA_COLS - 3);

    // Feed step being set up for the coming cycle (0 when leaving CLEAR)
    assign w_t_feed   = (r_state == ST_FEED) ? r_t + XW'(1) : '0;
    assign w_ifm_next = AW'(PW'(w_tr) * PW'(w_li) + PW'(w_t_feed));
    assign w_fil_next = AW'(PW'(w_tc) * PW'(w_lf) + PW'(w_t_feed));

    // Drain row being presented next (0 when leaving FEED)
    assign w_row_next  = (r_state == ST_DRAIN) ? r_row + LOG_R'(1) : '0;
    assign w_grow_cur  = (PW'(w_tr) << LOG_R) + PW'(r_row);
    assign w_grow_next = (PW'(w_tr) << LOG_R) + PW'(w_row_next);
    assign w_ofm_next  = AW'(w_grow_next * PW'(w_nt) + PW'(w_tc));
    // Valid rows are contiguous from row 0, so the tile ends at the array edge or at k
    assign w_last_row  = (r_row == LOG_R'(SA_ROWS - 1)) || (w_grow_cur + PW'(1) >= PW'(r_k));

    assign w_zero = (k == '0) || (m == '0) || (n == '0);
    assign w_clr  = (r_state == ST_IDLE) && start;
    assign w_adv  = (r_state == ST_DRAIN) && out_ready && w_last_row && !w_last_tile;

    sa_tile_counter #(
        .WIDTH(WIDTH)
    ) u_tile_counter (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .i_adv       (w_adv),
        .i_num_rows  (w_nr),
        .i_num_cols  (w_nt),
        .o_tr        (w_tr),
        .o_tc        (w_tc),
        .o_last_tile (w_last_tile)
    );

    // Job sequencer with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_m        <= '0;
            r_n        <= '0;
            r_t        <= '0;
            r_row      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_clear    <= 1'b0;
            r_valid    <= 1'b0;
            r_en_i     <= 1'b0;
            r_en_f     <= 1'b0;
            r_ifm_addr <= '0;
            r_fil_addr <= '0;
            r_ofm_addr <= '0;
        end else begin
            r_clear <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_k     <= k;
                        r_m     <= m;
                        r_n     <= n;
                        r_busy  <= 1'b1;
                        r_error <= w_zero;
                        if (w_zero) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_CLEAR;
                            r_clear <= 1'b1;
                        end
                    end
                end
                ST_CLEAR, ST_FEED: begin
                    if (r_state == ST_FEED && r_t == w_f_last) begin
                        r_state    <= ST_DRAIN;
                        r_en_i     <= 1'b0;
                        r_en_f     <= 1'b0;
                        r_valid    <= 1'b1;
                        r_row      <= w_row_next;
                        r_ofm_addr <= w_ofm_next;
                    end else begin
                        r_state <= ST_FEED;
                        r_t     <= w_t_feed;
                        if (w_t_feed < w_li) begin
                            r_en_i     <= 1'b1;
                            r_ifm_addr <= w_ifm_next;
                        end else begin
                            r_en_i <= 1'b0;
                        end
                        if (w_t_feed < w_lf) begin
                            r_en_f     <= 1'b1;
                            r_fil_addr <= w_fil_next;
                        end else begin
                            r_en_f <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (w_last_row) begin
                            r_valid <= 1'b0;
                            if (w_last_tile) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_CLEAR;
                                r_clear <= 1'b1;
                            end
                        end else begin
                            r_row      <= w_row_next;
                            r_ofm_addr <= w_ofm_next;
                        end
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_row      <= '0;
                    r_ifm_addr <= '0;
                    r_fil_addr <= '0;
                    r_ofm_addr <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy                 = r_busy;
    assign done                 = r_done;
    assign error                = r_error;
    assign ifmaps_addr          = r_ifm_addr;
    assign filters_addr         = r_fil_addr;
    assign enable_ifmaps_to_sa  = r_en_i;
    assign enable_filters_to_sa = r_en_f;
    assign clear_acc            = r_clear;
    assign ofmap_valid          = r_valid;
    assign ofmap_addr           = r_ofm_addr;
    assign drain_row            = r_row;

endmodule
